// File: rtl/serdes_rx_checker.sv
// ---------------------------------------------------------------------------
// serdes_rx_checker
//
// Receive-side link checker for the 8B/10B SerDes test path. It sits behind
// the RX decoder in the 100 MHz parallel clock domain. It qualifies the link
// by counting consecutive training words. Once locked, it checks that
// successive samples of the NCO sine stream never jump by more than
// MAX_DELTA.
//
// Optional feature macro: SERDES_CHECKER_WORD_CNT_EN
//   defined   -> 32-bit good-word counter drives word_cnt
//   undefined -> counter not built, word_cnt is constant 0
//
// Parameters:
//   TRAIN_WORD  training word sent before the data phase
//   LOCK_CNT    consecutive training words needed for lock (1..255)
//   MAX_DELTA   largest legal |sample - previous sample|
//   LOSS_CNT    consecutive data errors that drop the link (1..15)
//
// Ports:
//   clk         100 MHz parallel-domain clock
//   rst         synchronous active-high reset
//   enable      checker enable, low forces IDLE
//   align_done  RX bit alignment complete, low forces IDLE
//   data_valid  qualifies data_in
//   data_in     decoded receive word
//   clr_cnt     synchronous clear of err_cnt (an error in the same cycle wins)
//   link_up     link locked (DATA_WAIT or CHECK)
//   err_pulse   one-cycle pulse per continuity error
//   err_cnt     saturating error count
//   state       0 IDLE, 1 TRAIN, 2 DATA_WAIT, 3 CHECK
//   word_cnt    good data words checked (see macro above)
// ---------------------------------------------------------------------------
module serdes_rx_checker #(
    parameter logic [7:0]  TRAIN_WORD = 8'hA6,
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned MAX_DELTA  = 8,
    parameter int unsigned LOSS_CNT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        align_done,
    input  logic        data_valid,
    input  logic [7:0]  data_in,
    input  logic        clr_cnt,
    output logic        link_up,
    output logic        err_pulse,
    output logic [15:0] err_cnt,
    output logic [1:0]  state,
    output logic [31:0] word_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_TRAIN     = 2'd1,
        ST_DATA_WAIT = 2'd2,
        ST_CHECK     = 2'd3
    } state_e;

    // Comparing against "count minus one" lets the Nth event trigger the
    // transition on the very edge that samples it.
    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
    localparam logic [3:0] LOSS_LAST   = 4'(LOSS_CNT - 1);
    localparam logic [8:0] MAX_DELTA_W = 9'(MAX_DELTA);

    state_e      state_q, state_d;
    logic [7:0]  matchCnt_q, matchCnt_d;
    logic [3:0]  consErr_q, consErr_d;
    logic [7:0]  prev_q, prev_d;
    logic [15:0] errCnt_q, errCnt_d;
    logic        errPulse_q, errPulse_d;
    logic        linkUp_q, linkUp_d;

    logic        active;
    logic        isTrain;
    logic        deltaErr;
    logic        isErr;
    logic [8:0]  diff;
    logic [8:0]  delta;

    assign active  = enable && align_done;
    assign isTrain = (data_in == TRAIN_WORD);

    // 9-bit difference so 8'h00 against 8'hFF is a delta of 255, never a
    // wrapped small value; a borrow in bit 8 means the result needs negating.
    assign diff     = {1'b0, data_in} - {1'b0, prev_q};
    assign delta    = diff[8] ? (9'd0 - diff) : diff;
    assign deltaErr = (delta > MAX_DELTA_W);

    // Next-state logic. Dropping enable or align_done beats everything else.
    always_comb begin
        state_d    = state_q;
        matchCnt_d = matchCnt_q;
        consErr_d  = consErr_q;
        prev_d     = prev_q;
        isErr      = 1'b0;

        if (!active) begin
            state_d    = ST_IDLE;
            matchCnt_d = '0;
            consErr_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_TRAIN;
                    matchCnt_d = '0;
                    consErr_d  = '0;
                end
                ST_TRAIN: begin
                    if (data_valid) begin
                        if (!isTrain) begin
                            matchCnt_d = '0;
                        end else if (matchCnt_q == LOCK_LAST) begin
                            matchCnt_d = '0;
                            state_d    = ST_DATA_WAIT;
                        end else begin
                            matchCnt_d = matchCnt_q + 8'd1;
                        end
                    end
                end
                ST_DATA_WAIT: begin
                    // Trailing training words are skipped; the first real
                    // sample only seeds prev.
                    if (data_valid && !isTrain) begin
                        prev_d    = data_in;
                        consErr_d = '0;
                        state_d   = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (data_valid) begin
                        prev_d = data_in;
                        if (deltaErr) begin
                            isErr = 1'b1;
                            if (consErr_q == LOSS_LAST) begin
                                consErr_d = '0;
                                state_d   = ST_IDLE;
                            end else begin
                                consErr_d = consErr_q + 4'd1;
                            end
                        end else begin
                            consErr_d = '0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Error counter: clear first, then an error in the same cycle overrides
    // so a clear coinciding with an error leaves a count of one.
    always_comb begin
        errCnt_d = clr_cnt ? 16'd0 : errCnt_q;
        if (isErr) begin
            if (clr_cnt) begin
                errCnt_d = 16'd1;
            end else if (errCnt_q != 16'hFFFF) begin
                errCnt_d = errCnt_q + 16'd1;
            end
        end
        errPulse_d = isErr;
        linkUp_d   = (state_d == ST_DATA_WAIT) || (state_d == ST_CHECK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            matchCnt_q <= '0;
            consErr_q  <= '0;
            prev_q     <= '0;
            errCnt_q   <= '0;
            errPulse_q <= 1'b0;
            linkUp_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            matchCnt_q <= matchCnt_d;
            consErr_q  <= consErr_d;
            prev_q     <= prev_d;
            errCnt_q   <= errCnt_d;
            errPulse_q <= errPulse_d;
            linkUp_q   <= linkUp_d;
        end
    end

    assign link_up   = linkUp_q;
    assign err_pulse = errPulse_q;
    assign err_cnt   = errCnt_q;
    assign state     = state_q;

`ifdef SERDES_CHECKER_WORD_CNT_EN
    logic [31:0] wordCnt_q, wordCnt_d;
    logic        enterTrain;
    logic        goodWord;

    assign enterTrain = active && (state_q == ST_IDLE);
    assign goodWord   = active && (state_q == ST_CHECK) && data_valid && !deltaErr;

    // Counter restarts on every entry to TRAIN and wraps naturally at 2^32.
    always_comb begin
        wordCnt_d = wordCnt_q;
        if (enterTrain) begin
            wordCnt_d = '0;
        end else if (goodWord) begin
            wordCnt_d = wordCnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wordCnt_q <= '0;
        end else begin
            wordCnt_q <= wordCnt_d;
        end
    end

    assign word_cnt = wordCnt_q;
`else
    assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_serdes_rx_checker.sv
// ---------------------------------------------------------------------------
// tb_serdes_rx_checker
//
// Self-checking bench for serdes_rx_checker. A mode-level model follows the
// link behaviour word by word and is compared against the main DUT on every
// cycle. Directed sequences add literal expectations at the interesting
// points: lock, error, loss, abort and reset. A second instance with
// LOCK_CNT=1 and LOSS_CNT=15 drives err_cnt into saturation quickly.
// Word counter expectations follow SERDES_CHECKER_WORD_CNT_EN.
// ---------------------------------------------------------------------------
module tb_serdes_rx_checker;

    localparam logic [7:0] TW        = 8'hA6;
    localparam int         MAXD      = 8;
    localparam int         LOSS      = 4;
    localparam int         LOCK      = 16;

    localparam int M_IDLE  = 0;
    localparam int M_TRAIN = 1;
    localparam int M_WAIT  = 2;
    localparam int M_CHECK = 3;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        align_done;
    logic        data_valid;
    logic [7:0]  data_in;
    logic        clr_cnt;
    logic        link_up;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic [1:0]  state;
    logic [31:0] word_cnt;

    logic        satEn;
    logic        satValid;
    logic [7:0]  satData;
    logic        satClr;
    logic        satLink;
    logic        satPulse;
    logic [15:0] satErr;
    logic [1:0]  satState;
    logic [31:0] satWords;

    int          nChecks;
    int          nErrors;
    bit          chkOn;

    int          mMode;
    int          mMatch;
    int          mCons;
    int          mPrev;
    int          mErr;
    logic [31:0] mWords;
    bit          mPulse;
    bit          mIsErr;
    int          mDelta;

    serdes_rx_checker #(
        .TRAIN_WORD(TW), .LOCK_CNT(LOCK), .MAX_DELTA(MAXD), .LOSS_CNT(LOSS)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .align_done(align_done),
        .data_valid(data_valid), .data_in(data_in), .clr_cnt(clr_cnt),
        .link_up(link_up), .err_pulse(err_pulse), .err_cnt(err_cnt),
        .state(state), .word_cnt(word_cnt)
    );

    serdes_rx_checker #(
        .TRAIN_WORD(TW), .LOCK_CNT(1), .MAX_DELTA(MAXD), .LOSS_CNT(15)
    ) uSat (
        .clk(clk), .rst(rst), .enable(satEn), .align_done(satEn),
        .data_valid(satValid), .data_in(satData), .clr_cnt(satClr),
        .link_up(satLink), .err_pulse(satPulse), .err_cnt(satErr),
        .state(satState), .word_cnt(satWords)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural link model, advanced on the same edge the DUT samples.
    // It tracks the link mode, consecutive match/error counts and the last
    // sample as plain integers.
    always @(posedge clk) begin
        mIsErr = 1'b0;
        if (rst) begin
            mMode  = M_IDLE;
            mMatch = 0;
            mCons  = 0;
            mPrev  = 0;
            mErr   = 0;
            mWords = '0;
        end else begin
            if (!(enable && align_done)) begin
                mMode  = M_IDLE;
                mMatch = 0;
            end else if (mMode == M_IDLE) begin
                mMode  = M_TRAIN;
                mMatch = 0;
                mWords = '0;
            end else if (data_valid) begin
                if (mMode == M_TRAIN) begin
                    mMatch = (data_in == TW) ? mMatch + 1 : 0;
                    if (mMatch == LOCK) begin
                        mMode  = M_WAIT;
                        mMatch = 0;
                    end
                end else if (mMode == M_WAIT) begin
                    if (data_in != TW) begin
                        mPrev = int'(data_in);
                        mCons = 0;
                        mMode = M_CHECK;
                    end
                end else begin
                    mDelta = int'(data_in) - mPrev;
                    if (mDelta < 0) mDelta = -mDelta;
                    mPrev = int'(data_in);
                    if (mDelta > MAXD) begin
                        mIsErr = 1'b1;
                        mCons++;
                        if (mCons == LOSS) mMode = M_IDLE;
                    end else begin
                        mCons  = 0;
                        mWords = mWords + 32'd1;
                    end
                end
            end
            if (clr_cnt) mErr = 0;
            if (mIsErr && mErr < 65535) mErr++;
        end
        mPulse = mIsErr;
    end

    // Every-cycle comparison of the main DUT against the model, on the
    // falling edge so both sides have settled.
    always @(negedge clk) begin
        if (chkOn) begin
            checkOutput("state", 32'(state), 32'(mMode));
            checkOutput("link_up", 32'(link_up), 32'(mMode >= M_WAIT));
            checkOutput("err_pulse", 32'(err_pulse), 32'(mPulse));
            checkOutput("err_cnt", 32'(err_cnt), 32'(mErr));
`ifdef SERDES_CHECKER_WORD_CNT_EN
            checkOutput("word_cnt", word_cnt, mWords);
`else
            checkOutput("word_cnt", word_cnt, 32'd0);
`endif
        end
    end

    // Drive one word to the main DUT and wait until just after it is sampled.
    task automatic applyStimulus(input logic v, input logic [7:0] d);
        data_valid = v;
        data_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic satStep(input logic v, input logic [7:0] d, input logic c);
        satValid = v;
        satData  = d;
        satClr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic trainWords(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, TW);
    endtask

    // Pass through IDLE for one cycle and come back into TRAIN.
    task automatic restartLink();
        enable = 1'b0;
        applyStimulus(1'b0, 8'h00);
        enable = 1'b1;
        applyStimulus(1'b0, 8'h00);
    endtask

    initial begin
        int          errs;
        int          cons;
        logic [7:0]  cur;

        nChecks = 0; nErrors = 0; chkOn = 1'b0;
        rst = 1'b1; enable = 1'b0; align_done = 1'b0;
        data_valid = 1'b0; data_in = 8'h00; clr_cnt = 1'b0;
        satEn = 1'b0; satValid = 1'b0; satData = 8'h00; satClr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chkOn = 1'b1;
        checkOutput("reset state", 32'(state), 32'd0);
        checkOutput("reset link_up", 32'(link_up), 32'd0);
        checkOutput("reset err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("reset word_cnt", word_cnt, 32'd0);
        rst = 1'b0;

        // Basic lock on sixteen training words
        enable = 1'b1; align_done = 1'b1;
        applyStimulus(1'b0, 8'h00);
        checkOutput("enter TRAIN", 32'(state), 32'd1);
        trainWords(15);
        checkOutput("no lock at 15", 32'(link_up), 32'd0);
        trainWords(1);
        checkOutput("lock state", 32'(state), 32'd2);
        checkOutput("lock link_up", 32'(link_up), 32'd1);

        // A broken run must restart the match count
        restartLink();
        trainWords(10);
        applyStimulus(1'b1, 8'h00);
        trainWords(15);
        checkOutput("no early lock", 32'(link_up), 32'd0);
        trainWords(1);
        checkOutput("relock state", 32'(state), 32'd2);

        // Continuity: 80 -> 84 good, 84 -> 90 error (delta 12)
        applyStimulus(1'b1, TW);
        applyStimulus(1'b0, 8'h55);
        applyStimulus(1'b1, 8'h80);
        checkOutput("enter CHECK", 32'(state), 32'd3);
        applyStimulus(1'b1, 8'h84);
        checkOutput("good no pulse", 32'(err_pulse), 32'd0);
        applyStimulus(1'b0, 8'hFF);
        applyStimulus(1'b1, 8'h90);
        checkOutput("delta12 pulse", 32'(err_pulse), 32'd1);
        checkOutput("delta12 err_cnt", 32'(err_cnt), 32'd1);
        checkOutput("delta12 link_up", 32'(link_up), 32'd1);
`ifdef SERDES_CHECKER_WORD_CNT_EN
        checkOutput("one good word", word_cnt, 32'd1);
`else
        checkOutput("word_cnt off", word_cnt, 32'd0);
`endif
        applyStimulus(1'b0, 8'h00);
        checkOutput("pulse one cycle", 32'(err_pulse), 32'd0);

        // Four consecutive full-swing errors drop the link
        restartLink();
        trainWords(16);
        applyStimulus(1'b1, 8'h80);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'hFF);
        applyStimulus(1'b1, 8'h00);
        checkOutput("3 errs still up", 32'(link_up), 32'd1);
        applyStimulus(1'b1, 8'hFF);
        checkOutput("loss pulse", 32'(err_pulse), 32'd1);
        checkOutput("loss state", 32'(state), 32'd0);
        checkOutput("loss link_up", 32'(link_up), 32'd0);
        checkOutput("loss err_cnt", 32'(err_cnt), 32'd5);

        // align_done drop for one cycle while in CHECK
        applyStimulus(1'b0, 8'h00);
        trainWords(16);
        applyStimulus(1'b1, 8'h80);
        applyStimulus(1'b1, 8'h84);
        align_done = 1'b0;
        applyStimulus(1'b1, 8'h84);
        checkOutput("abort state", 32'(state), 32'd0);
        checkOutput("abort err kept", 32'(err_cnt), 32'd5);
        align_done = 1'b1;

        // Reset mid-training clears everything even with enable high
        applyStimulus(1'b0, 8'h00);
        trainWords(5);
        rst = 1'b1;
        applyStimulus(1'b1, TW);
        checkOutput("mid rst state", 32'(state), 32'd0);
        checkOutput("mid rst err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        enable = 1'b0;
        applyStimulus(1'b0, 8'h00);

        // Saturation instance: lock on one word, then never more than 14
        // consecutive errors so the link stays up.
        satEn = 1'b1;
        satStep(1'b0, 8'h00, 1'b0);
        satStep(1'b1, TW, 1'b0);
        satStep(1'b1, 8'h00, 1'b0);
        checkOutput("sat CHECK", 32'(satState), 32'd3);
        errs = 0; cons = 0; cur = 8'h00;
        while (errs < 65535) begin
            if (cons == 14) begin
                satStep(1'b1, cur, 1'b0);
                cons = 0;
            end else begin
                cur = ~cur;
                satStep(1'b1, cur, 1'b0);
                errs++;
                cons++;
            end
        end
        checkOutput("sat reach max", 32'(satErr), 32'hFFFF);
        satStep(1'b1, cur, 1'b0);
        cur = ~cur;
        satStep(1'b1, cur, 1'b0);
        checkOutput("sat hold pulse", 32'(satPulse), 32'd1);
        checkOutput("sat hold", 32'(satErr), 32'hFFFF);
        satStep(1'b0, 8'h00, 1'b1);
        checkOutput("clr no err", 32'(satErr), 32'd0);
        cur = ~cur;
        satStep(1'b1, cur, 1'b1);
        checkOutput("clr with err", 32'(satErr), 32'd1);
        checkOutput("clr pulse", 32'(satPulse), 32'd1);
        satStep(1'b0, 8'h00, 1'b0);

        chkOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
